// File: rtl/sw_debounce4.sv
// rtl/sw_debounce4.sv - four-channel slide-switch debouncer
//
// Purpose: each of four raw switch levels passes through a two-flop
// synchronizer. The debounced level follows the synchronized level only
// after the two have disagreed for STABLE_CYCLES consecutive clock edges.
// The four channels are fully independent.
//
// Ports:
//   clk      - system clock; all state changes on its rising edge
//   rst_n    - asynchronous active-low reset (release is already synchronous)
//   sw       - raw asynchronous switch levels [6:3]
//   sw_db    - debounced levels [6:3], driven straight from flops
//   sw_rise  - one-cycle pulse after sw_db bit goes 0->1 (DEBOUNCE_EDGE_EN only)
//   sw_fall  - one-cycle pulse after sw_db bit goes 1->0 (DEBOUNCE_EDGE_EN only)
//
// Build option: define DEBOUNCE_EDGE_EN to add the sw_rise/sw_fall ports.
// Parameters: STABLE_CYCLES in 1..2^CNT_W-1.

module sw_debounce4 #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:3] sw,
  output logic [6:3] sw_db
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [6:3] sw_rise,
  output logic [6:3] sw_fall
`endif
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar i = 3; i <= 6; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             db;
    logic             db_nx;
    logic             load;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    // Synchronizer: nothing downstream looks at sw before s2.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= sw[i];
        s2 <= s1;
      end
    end

    // State register, counter and debounced output flop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_STABLE;
        cnt   <= '0;
        db    <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        db    <= db_nx;
      end
    end

    // Next state. The counter advances on every edge that sees a mismatch,
    // including the first one out of STABLE, so the load lands on the
    // STABLE_CYCLES-th consecutive mismatching edge. Clearing on load keeps
    // the counter from ever wrapping.
    always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      load     = 1'b0;
      case (state)
        ST_STABLE: begin
          if (s2 != db) begin
            if (cnt == CNT_LAST) begin
              load = 1'b1;
            end else begin
              state_nx = ST_PENDING;
              cnt_nx   = cnt + CNT_ONE;
            end
          end
        end
        ST_PENDING: begin
          if (s2 == db) begin
            state_nx = ST_STABLE;
          end else if (cnt == CNT_LAST) begin
            load     = 1'b1;
            state_nx = ST_STABLE;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: state_nx = ST_STABLE;
      endcase
    end

    // Outputs.
    always_comb begin
      db_nx = load ? s2 : db;
    end

    assign sw_db[i] = db;

`ifdef DEBOUNCE_EDGE_EN
    logic rise;
    logic fall;
    logic rise_nx;
    logic fall_nx;

    always_comb begin
      rise_nx = load & s2;
      fall_nx = load & ~s2;
    end

    // Pulses are registered alongside db, so they are high during exactly
    // the cycle after the edge that changed sw_db.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise <= 1'b0;
        fall <= 1'b0;
      end else begin
        rise <= rise_nx;
        fall <= fall_nx;
      end
    end

    assign sw_rise[i] = rise;
    assign sw_fall[i] = fall;
`endif
  end

endmodule

// File: doc/sw_debounce4.md
SW_DEBOUNCE4 -- requirements
Module: sw_debounce4

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 50000, meaning clock cycles a synchronized input must differ from its output before the output follows (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning stability counter width per channel.
REQ-003 STABLE_CYCLES SHALL be in range 1..2^CNT_W-1; other values are unsupported.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sw  input  [6:3]  raw asynchronous slide-switch levels.
REQ-007 sw_db  output  [6:3]  debounced, clock-synchronous switch levels; sw_db[6:3] drive the a/b/c/d inputs of the downstream 4-input majority voter.
REQ-008 sw_rise  output  [6:3]  one-cycle pulse when sw_db bit goes 0->1 (present only with DEBOUNCE_EDGE_EN).
REQ-009 sw_fall  output  [6:3]  one-cycle pulse when sw_db bit goes 1->0 (present only with DEBOUNCE_EDGE_EN).

Function
REQ-010 Each of the four channels SHALL be independent and identical; no shared counter.
REQ-011 Each channel SHALL pass sw through a two-flop synchronizer (s1, s2) before any other use.
REQ-012 Each channel SHALL be a two-state machine: STABLE (s2 == sw_db, counter held 0) and PENDING (s2 != sw_db, counter incrementing by 1 per cycle).
REQ-013 In PENDING, if s2 returns to equal sw_db, the channel SHALL return to STABLE and clear the counter at that edge; sw_db unchanged.
REQ-014 In PENDING, when counter == STABLE_CYCLES-1 and s2 still != sw_db, sw_db SHALL load s2 and the counter SHALL clear at that edge (back to STABLE).
REQ-015 Latency: with edge 0 the first edge sampling a new steady sw level into s1, sw_db SHALL change at edge STABLE_CYCLES+1, never earlier.
REQ-016 Any glitch on sw shorter than STABLE_CYCLES cycles (after synchronization) SHALL produce no change on sw_db.
REQ-017 The counter SHALL never wrap; it saturates logically by the REQ-014 clear.
REQ-018 Simultaneous changes on several channels SHALL each complete on their own schedule; equal-timed changes update in the same cycle.
REQ-019 sw_db SHALL be driven directly from flops (no combinational path from sw).

Reset
REQ-020 Asserting rst_n low SHALL immediately clear s1, s2, sw_db, all counters, and (if present) sw_rise/sw_fall to 0, regardless of clk.
REQ-021 Reset asserted mid-PENDING SHALL abandon the pending change; after release, a high sw SHALL take the full REQ-015 latency to reach sw_db.
REQ-022 Release of rst_n is synchronous to clk by the board-level reset; the block SHALL add no reset synchronizer.

Configuration
REQ-023 Macro DEBOUNCE_EDGE_EN SHALL, when defined, add ports sw_rise and sw_fall, registered, asserted for exactly the one cycle following the edge at which the corresponding sw_db bit changes.
REQ-024 Without DEBOUNCE_EDGE_EN, sw_rise/sw_fall and their flops SHALL be absent and sw_db behaviour SHALL be identical.

Verification (STABLE_CYCLES=4, CNT_W=4)
REQ-025 Reset: rst_n=0 with sw=4'hF, clk running -> sw_db=0, sw_rise=sw_fall=0 throughout; release -> sw_db=4'hF exactly 5 edges after first sampling edge.
REQ-026 Glitch: sw[5] high for 3 cycles then low -> sw_db[5] stays 0, no sw_rise pulse.
REQ-027 Clean step: sw 4'h0->4'h6 held -> sw_db=4'h6 at edge 5; sw_rise=4'h6 for one cycle then 0; voter output 0.
REQ-028 Bounce: sw[3] toggles every 2 cycles for 20 cycles then held 1 -> sw_db[3] rises only 5 edges after the final transition.
REQ-029 Reset mid-pending: sw[6] 0->1, rst_n pulsed low at edge 3 -> sw_db[6] 0; after release sw_db[6]=1 5 edges after first post-reset sample.
REQ-030 Fall: from sw_db=4'hF, sw=4'h7 held -> sw_db=4'h7 at edge 5, sw_fall=4'h8 for one cycle; voter output stays 1.
